// File: rtl/lcd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_sched_pkg
// Description : Shared types and constants for the LCD text scheduler:
//               FSM state encoding, owner code for "no owner", blank line,
//               timing defaults and the cursor clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_sched_pkg;

    // Default cycle counts (clk_100hz cycles)
    localparam int MIN_GAP_DEF    = 45;
    localparam int HOLD_TICKS_DEF = 200;

    // Owner code meaning "nobody owns the display"
    localparam logic [1:0] OWNER_NONE = 2'd3;

    // Sixteen ASCII spaces: one blank LCD line
    localparam logic [127:0] SPACE_LINE = {16{8'h20}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNAP   = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // Only the visible columns of the two lines (0x00-0x0F, 0x40-0x4F) are
    // legal cursor positions; anything else parks the cursor at home.
    function automatic logic [6:0] clamp_cursor(input logic [6:0] cur);
        if ((cur[6:4] == 3'b000) || (cur[6:4] == 3'b100)) begin
            return cur;
        end
        return 7'h00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_sched_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : lcd_sched_prio_enc
// Description : Combinational winner selection. Alert (2) beats admin (1)
//               beats vending UI (0); an active alert lock keeps source 2 as
//               the winner while it owns the display.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_sched_prio_enc
    import lcd_sched_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_owner,
    input  logic       i_alert_lock,
    output logic [1:0] o_winner
);

    // Fixed-priority pick, overridden by the alert lock
    always_comb begin
        o_winner = OWNER_NONE;
        if (i_alert_lock && (i_owner == 2'd2)) begin
            o_winner = 2'd2;
        end else if (i_req[2]) begin
            o_winner = 2'd2;
        end else if (i_req[1]) begin
            o_winner = 2'd1;
        end else if (i_req[0]) begin
            o_winner = 2'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_text_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lcd_text_scheduler
// Description : Arbitrates three text sources onto a two-line LCD. On an
//               ownership change or a content update from the owner, the
//               winner's text and cursor are snapshotted, a one-cycle
//               rewrite strobe is issued, and a redraw gap is enforced.
//               Optional build macro LCD_SCHED_ALERT_HOLD_EN: once the
//               alert source owns the display it keeps it for at least
//               HOLD_TICKS cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_text_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int MIN_GAP    = MIN_GAP_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic         clk_100hz,
    input  logic         rst,
    input  logic [2:0]   req,
    input  logic [2:0]   upd,
    input  logic [767:0] src_text,
    input  logic [20:0]  src_cursor,
    output logic [127:0] line1_text,
    output logic [127:0] line2_text,
    output logic [6:0]   ddram_address,
    output logic         rewrite,
    output logic [1:0]   owner,
    output logic [2:0]   ack
);

    localparam int             GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [2:0]     r_pend;
    logic [127:0]   r_line1;
    logic [127:0]   r_line2;
    logic [6:0]     r_addr;
    logic           r_rewrite;
    logic [1:0]     r_owner;
    logic [2:0]     r_ack;

    logic [1:0]     w_winner;
    logic           w_alert_lock;
    logic [3:0]     w_pend_ext;
    logic           w_trigger;
    logic           w_snap;
    logic           w_strobe;
    logic [127:0]   w_sel_line1;
    logic [127:0]   w_sel_line2;
    logic [6:0]     w_sel_cursor;
    logic [2:0]     w_sel_ack;

    lcd_sched_prio_enc u_prio_enc (
        .i_req        (req),
        .i_owner      (r_owner),
        .i_alert_lock (w_alert_lock),
        .o_winner     (w_winner)
    );

`ifdef LCD_SCHED_ALERT_HOLD_EN
    localparam int               HOLD_W   = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

    logic [HOLD_W-1:0] r_hold_cnt;

    // Alert ownership age, restarted by every snapshot, saturating
    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
        end else if (w_snap) begin
            r_hold_cnt <= '0;
        end else if ((r_owner == 2'd2) && (r_hold_cnt != HOLD_MAX)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign w_alert_lock = (r_owner == 2'd2) && (r_hold_cnt < HOLD_MAX);
`else
    assign w_alert_lock = 1'b0;
`endif

    // A spare zero bit lets the "no owner" code index the pending vector
    assign w_pend_ext = {1'b0, r_pend};
    assign w_trigger  = (w_winner != r_owner) || w_pend_ext[r_owner];

    // Source mux: text, clamped cursor and ack bit of the current winner
    always_comb begin
        w_sel_line1  = SPACE_LINE;
        w_sel_line2  = SPACE_LINE;
        w_sel_cursor = 7'h00;
        w_sel_ack    = 3'b000;
        case (w_winner)
            2'd0: begin
                w_sel_line1  = src_text[255:128];
                w_sel_line2  = src_text[127:0];
                w_sel_cursor = clamp_cursor(src_cursor[6:0]);
                w_sel_ack    = 3'b001;
            end
            2'd1: begin
                w_sel_line1  = src_text[511:384];
                w_sel_line2  = src_text[383:256];
                w_sel_cursor = clamp_cursor(src_cursor[13:7]);
                w_sel_ack    = 3'b010;
            end
            2'd2: begin
                w_sel_line1  = src_text[767:640];
                w_sel_line2  = src_text[639:512];
                w_sel_cursor = clamp_cursor(src_cursor[20:14]);
                w_sel_ack    = 3'b100;
            end
            default: begin
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-state action strobes
    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        w_strobe    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = ST_SNAP;
                end
            end
            ST_SNAP: begin
                w_snap      = 1'b1;
                w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                w_strobe    = 1'b1;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, pending flags and redraw-gap counter
    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            r_gap_cnt <= '0;
            r_pend    <= 3'b000;
            r_line1   <= SPACE_LINE;
            r_line2   <= SPACE_LINE;
            r_addr    <= 7'h00;
            r_rewrite <= 1'b0;
            r_owner   <= OWNER_NONE;
            r_ack     <= 3'b000;
        end else begin
            r_rewrite <= w_strobe;
            r_ack     <= 3'b000;
            // A capture clears its pend bit even if upd arrives on that edge,
            // so one change never produces two snapshots.
            r_pend    <= (r_pend | upd) & ~(w_snap ? w_sel_ack : 3'b000);
            if ((r_state == ST_GAP) && (r_gap_cnt != GAP_LAST)) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_snap) begin
                r_line1 <= w_sel_line1;
                r_line2 <= w_sel_line2;
                r_addr  <= w_sel_cursor;
                r_owner <= w_winner;
                r_ack   <= w_sel_ack;
            end
        end
    end

    assign line1_text    = r_line1;
    assign line2_text    = r_line2;
    assign ddram_address = r_addr;
    assign rewrite       = r_rewrite;
    assign owner         = r_owner;
    assign ack           = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_text_scheduler
// Description : Scoreboard bench for lcd_text_scheduler. An edge-level
//               reference model predicts each snapshot (content, owner,
//               ack, rewrite edge); a negedge monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_text_scheduler;

    localparam int           MG    = 45;
    localparam int           HT    = 200;
    localparam logic [1:0]   NONE  = 2'd3;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic         clk_100hz = 1'b0;
    logic         rst       = 1'b0;
    logic [2:0]   req       = 3'b000;
    logic [2:0]   upd       = 3'b000;
    logic [767:0] src_text  = '0;
    logic [20:0]  src_cursor = '0;
    logic [127:0] line1_text;
    logic [127:0] line2_text;
    logic [6:0]   ddram_address;
    logic         rewrite;
    logic [1:0]   owner;
    logic [2:0]   ack;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint edge_n   = 0;

    typedef struct {
        logic [1:0]   owner;
        logic [2:0]   ack;
        logic [127:0] l1;
        logic [127:0] l2;
        logic [6:0]   addr;
        longint       redge;
    } exp_t;

    exp_t exp_q[$];

    lcd_text_scheduler dut (
        .clk_100hz     (clk_100hz),
        .rst           (rst),
        .req           (req),
        .upd           (upd),
        .src_text      (src_text),
        .src_cursor    (src_cursor),
        .line1_text    (line1_text),
        .line2_text    (line2_text),
        .ddram_address (ddram_address),
        .rewrite       (rewrite),
        .owner         (owner),
        .ack           (ack)
    );

    always #5 clk_100hz = ~clk_100hz;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not met", name);
    endtask

    // ------------------------------------------------------------------
    // Reference model: decisions at edges, plain arithmetic on edge index
    // ------------------------------------------------------------------
    logic [1:0] m_owner   = NONE;
    logic [2:0] m_pend    = 3'b000;
    logic [2:0] m_ack     = 3'b000;
    longint     m_free    = 0;
    longint     m_snap_at = -1;
    longint     m_alert_s = 0;

    function automatic logic [6:0] ref_clamp(input logic [6:0] c);
        int v;
        v = int'(c);
        if ((v <= 15) || ((v >= 64) && (v <= 79))) return c;
        return 7'h00;
    endfunction

    function automatic logic [1:0] ref_winner(input logic [2:0] r);
        bit lock;
        lock = 1'b0;
`ifdef LCD_SCHED_ALERT_HOLD_EN
        // Alert keeps the display until it has owned it for HT cycles
        lock = (m_owner == 2'd2) && ((edge_n - 1 - m_alert_s) < HT);
`endif
        if (lock)  return 2'd2;
        if (r[2])  return 2'd2;
        if (r[1])  return 2'd1;
        if (r[0])  return 2'd0;
        return NONE;
    endfunction

    always @(posedge clk_100hz) begin : p_model
        logic [2:0] clr;
        logic [1:0] w;
        int         b;
        exp_t       e;
        edge_n++;
        if (!rst) begin
            m_owner   = NONE;
            m_pend    = 3'b000;
            m_ack     = 3'b000;
            m_free    = edge_n + 1;
            m_snap_at = -1;
            exp_q.delete();
        end else begin
            clr   = 3'b000;
            m_ack = 3'b000;
            if (m_snap_at == edge_n) begin
                w       = ref_winner(req);
                e.owner = w;
                e.redge = edge_n + 1;
                if (w == NONE) begin
                    e.ack  = 3'b000;
                    e.l1   = BLANK;
                    e.l2   = BLANK;
                    e.addr = 7'h00;
                end else begin
                    b      = int'(w);
                    e.ack  = 3'b001 << b;
                    e.l1   = src_text[256*b+128 +: 128];
                    e.l2   = src_text[256*b +: 128];
                    e.addr = ref_clamp(src_cursor[7*b +: 7]);
                    clr    = e.ack;
                end
                exp_q.push_back(e);
                m_owner   = w;
                m_ack     = e.ack;
                m_alert_s = edge_n;
                m_snap_at = -1;
                m_free    = edge_n + MG + 2;
            end else if ((m_snap_at < 0) && (edge_n >= m_free)) begin
                w = ref_winner(req);
                if ((w != m_owner) || ((m_owner != NONE) && m_pend[m_owner])) begin
                    m_snap_at = edge_n + 1;
                end
            end
            m_pend = (m_pend | upd) & ~clr;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares DUT against model and the expected-snapshot queue
    // ------------------------------------------------------------------
    longint last_rw = -1;

    always @(negedge clk_100hz) begin : p_mon
        exp_t e;
        if (!rst) begin
            last_rw = -1;
        end else begin
            check("owner", 128'(owner), 128'(m_owner));
            check("ack", 128'(ack), 128'(m_ack));
            if (rewrite) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rewrite");
                end else begin
                    e = exp_q.pop_front();
                    check("rewrite_edge", 128'(edge_n), 128'(e.redge));
                    check("snap_owner", 128'(owner), 128'(e.owner));
                    check("line1", line1_text, e.l1);
                    check("line2", line2_text, e.l2);
                    check("ddram", 128'(ddram_address), 128'(e.addr));
                    if (last_rw >= 0) begin
                        n_checks++;
                        if ((edge_n - last_rw) < (MG + 2)) begin
                            n_fail++;
                            $display("FAIL rewrite_spacing: got %0d, expected >= %0d", edge_n - last_rw, MG + 2);
                        end
                    end
                    last_rw = edge_n;
                end
            end else if ((exp_q.size() > 0) && (exp_q[0].redge <= edge_n)) begin
                e = exp_q.pop_front();
                fail_now("missing_rewrite");
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk_100hz);
        #1;
    endtask

    task automatic settle();
        repeat (MG + 8) tick();
    endtask

    task automatic set_src(input int s, input logic [127:0] l1, input logic [127:0] l2, input logic [6:0] c);
        src_text[256*s+128 +: 128] = l1;
        src_text[256*s +: 128]     = l2;
        src_cursor[7*s +: 7]       = c;
    endtask

    task automatic pulse_upd(input logic [2:0] u);
        upd = u;
        tick();
        upd = 3'b000;
    endtask

    task automatic wait_owner(input logic [1:0] o, input int lim);
        int n;
        n = 0;
        while ((owner !== o) && (n < lim)) begin
            tick();
            n++;
        end
        if (owner !== o) fail_now("wait_owner_timeout");
    endtask

    task automatic check_reset_state();
        check("rst_line1", line1_text, BLANK);
        check("rst_line2", line2_text, BLANK);
        check("rst_ddram", 128'(ddram_address), 128'(7'h00));
        check("rst_rewrite", 128'(rewrite), 128'(1'b0));
        check("rst_ack", 128'(ack), 128'(3'b000));
        check("rst_owner", 128'(owner), 128'(NONE));
    endtask

    initial begin : p_stim
        int n2;
        int s;
        int n;
        set_src(0, "COLA 1200 WON   ", "INSERT COIN     ", 7'h05);
        set_src(1, "ADMIN MODE      ", "SERVICE MENU    ", 7'h42);
        set_src(2, "ALERT: DOOR OPEN", "CALL OPERATOR   ", 7'h4F);
        repeat (3) tick();
        check_reset_state();
        rst = 1'b1;
        tick();

        // First snapshot: ack after 2 edges, rewrite after 3
        req = 3'b001;
        tick();
        check("lat_ack_early", 128'(ack), 128'(3'b000));
        tick();
        check("lat_ack", 128'(ack), 128'(3'b001));
        check("lat_rewrite_early", 128'(rewrite), 128'(1'b0));
        tick();
        check("lat_rewrite", 128'(rewrite), 128'(1'b1));
        check("first_owner", 128'(owner), 128'(2'd0));
        check("first_ddram", 128'(ddram_address), 128'(7'h05));

        // Request change in the middle of the redraw gap is held off
        repeat (10) tick();
        req = 3'b011;
        repeat (5) tick();
        check("gap_holdoff_owner", 128'(owner), 128'(2'd0));
        settle();
        check("after_gap_owner", 128'(owner), 128'(2'd1));

        // Non-owner update stays pending; owner update re-snapshots
        pulse_upd(3'b001);
        repeat (3) tick();
        src_text[511:384] = "ADMIN MODE  v2  ";
        pulse_upd(3'b010);
        settle();
        check("resnap_line1", line1_text, 128'("ADMIN MODE  v2  "));
        req = 3'b001;
        settle();
        check("src0_back_owner", 128'(owner), 128'(2'd0));

        // Out-of-range cursor is parked at home; no requester blanks display
        set_src(1, "BAD CURSOR      ", "                ", 7'h25);
        req = 3'b010;
        settle();
        check("clamp_ddram", 128'(ddram_address), 128'(7'h00));
        req = 3'b000;
        settle();
        check("none_owner", 128'(owner), 128'(NONE));
        check("none_line1", line1_text, BLANK);

        // Short alert pulse
        req = 3'b001;
        settle();
        req = 3'b101;
        repeat (5) tick();
        req = 3'b001;
        wait_owner(2'd2, 20);
        n2 = 0;
        while ((owner == 2'd2) && (n2 < 1000)) begin
            tick();
            n2++;
        end
        n_checks++;
`ifdef LCD_SCHED_ALERT_HOLD_EN
        if (n2 < HT) begin
            n_fail++;
            $display("FAIL alert_hold: got %0d cycles, expected >= %0d", n2, HT);
        end
`else
        if (n2 >= HT) begin
            n_fail++;
            $display("FAIL alert_release: got %0d cycles, expected < %0d", n2, HT);
        end
`endif
        settle();
        check("alert_revert_owner", 128'(owner), 128'(2'd0));

        // Reset during STROBE aborts the rewrite
        req = 3'b000;
        settle();
        req = 3'b001;
        n = 0;
        while ((ack == 3'b000) && (n < 10)) begin
            tick();
            n++;
        end
        if (ack == 3'b000) fail_now("strobe_ack_timeout");
        rst = 1'b0;
        tick();
        check("abort_rewrite", 128'(rewrite), 128'(1'b0));
        tick();
        check("abort_rewrite2", 128'(rewrite), 128'(1'b0));
        check_reset_state();
        rst = 1'b1;
        tick();
        tick();
        check("fresh_ack", 128'(ack), 128'(3'b001));
        tick();
        check("fresh_rewrite", 128'(rewrite), 128'(1'b1));
        settle();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            upd = 3'b000;
            if ($urandom_range(0, 39) == 0) req = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 7) == 0) upd[k] = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) begin
                s = int'($urandom_range(0, 2));
                set_src(s, {$urandom, $urandom, $urandom, $urandom},
                        {$urandom, $urandom, $urandom, $urandom}, 7'($urandom_range(0, 127)));
            end
            if ($urandom_range(0, 1499) == 0) begin
                rst = 1'b0;
                tick();
                tick();
                rst = 1'b1;
            end
            tick();
        end
        upd = 3'b000;
        settle();
        settle();
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
